seq_shifter: RTL
================

// Module: seq_shifter
// PURPOSE
//   Parametrised multi-cycle shifter: the sequential successor of the 4-bit combinational shifter.
//   Adds configurable WIDTH, four shift modes, and valid/ready handshakes on input and output.
//   Shifts one bit position per clock, so a wide datapath needs no barrel network.
//   Sits between the control FSM (operand source) and the result register file (sink).
// PARAMETERS
//   WIDTH  8  data width in bits; must be >= 2
//   AMT_W  4  shift-amount width; amounts 0 .. 2^AMT_W-1 are accepted
// PORTS
//   clk        in   1      rising-edge clock; the only clock in the block
//   rst_n      in   1      asynchronous reset, active low
//   in_valid   in   1      operand presented
//   in_ready   out  1      block can accept an operand (state IDLE)
//   in_data    in   WIDTH  operand
//   in_amt     in   AMT_W  shift amount
//   in_mode    in   2      00 LSL, 01 LSR, 10 ASR, 11 ROL
//   out_valid  out  1      result available (state DONE)
//   out_ready  in   1      sink accepts the result
//   out_data   out  WIDTH  result
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, out_valid=0, out_data=0, busy=0, internal count=0; in_ready=1.
//     - Takes effect immediately, including mid-operation; the operation in flight is discarded.
//     - in_valid is ignored while rst_n=0.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE:
//     - in_ready=1.
//     - On in_valid at a rising edge (the accept edge): latch in_data into the working register, latch in_mode.
//     - Load cnt = eff_amt.
//     - eff_amt = min(in_amt, WIDTH) for LSL/LSR/ASR; eff_amt = in_amt for ROL (no modulo).
//     - If eff_amt==0, go to DONE; else go to SHIFT.
//   SHIFT (one step per edge, then cnt decrements):
//     - LSL: {w[WIDTH-2:0],1'b0}
//     - LSR: {1'b0,w[WIDTH-1:1]}
//     - ASR: {w[WIDTH-1],w[WIDTH-1:1]}
//     - ROL: {w[WIDTH-2:0],w[WIDTH-1]}
//     - The step at which cnt goes 1->0 moves the FSM to DONE.
//   DONE:
//     - out_valid=1; out_data is the working register, held stable until handshake.
//     - On out_valid & out_ready at an edge, go to IDLE; in_ready=1 in the following cycle.
//   Latency: out_valid first high in the cycle after edge (accept edge + eff_amt).
//     - eff_amt=0: the cycle right after the accept edge.
//     - Maximum: WIDTH edges for non-rotate modes; 2^AMT_W-1 edges for ROL.
//   Handshake rules:
//     - in_ready=0 in SHIFT and DONE. in_valid, in_data, in_amt and in_mode are ignored there.
//     - There is no overlap: a new operand is accepted only after the result handshake completes.
//     - out_valid never drops without out_ready. out_data changes only in SHIFT or at accept.
//   Saturation:
//     - eff_amt >= WIDTH gives 0 for LSL/LSR.
//     - eff_amt >= WIDTH gives all copies of the sign bit for ASR.
//     - ROL by any amount equals rotation by amt mod WIDTH.
//   out_ready held high in DONE: the handshake completes on the first DONE edge.
//   out_data is undefined-free: it retains its last value in IDLE (0 after reset).
// TESTING (WIDTH=8, AMT_W=4)
//   1. LSL in_data=8'hB3, amt=3 -> out_data=8'h98; out_valid 3 edges after accept.
//   2. ASR 8'h90 amt=2 -> 8'hE4 after 2 edges.
//      ASR 8'h90 amt=12 -> 8'hFF; latency clamped to 8.
//   3. LSR 8'h90 amt=0 -> 8'h90; out_valid in the cycle right after accept.
//      LSL 8'hFF amt=15 -> 8'h00 after 8 edges.
//   4. ROL 8'h81 amt=9 -> 8'h03; latency 9 edges.
//   5. Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and changing in_data.
//      -> out_data stable, in_ready=0, nothing accepted.
//      Then raise out_ready -> IDLE; next operand accepted one cycle later and gives its correct result.
//   6. Reset mid-SHIFT: drop rst_n asynchronously during ROL amt=9 (after 4 edges).
//      -> out_valid=0, busy=0, out_data=0 immediately, with no clock edge.
//      After release, LSR 8'h80 amt=7 -> 8'h01.

Source files
------------

// File: rtl/seq_shifter.sv
// seq_shifter: one-bit-per-clock LSL/LSR/ASR/ROL with valid/ready on operand and result.
// Result valid eff_amt edges after accept; held in DONE until out_ready; in_ready low while busy.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Counter must hold either the raw rotate amount or the clamp value WIDTH.
  localparam int CLAMP_W = $clog2(WIDTH + 1);
  localparam int CNT_W   = (AMT_W > CLAMP_W) ? AMT_W : CLAMP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic [CNT_W-1:0] amt_ext;
  logic [CNT_W-1:0] eff_amt;
  logic [WIDTH-1:0] step_dat;

  assign amt_ext = CNT_W'(in_amt);

  // Non-rotate modes saturate after WIDTH steps; ROL keeps the full amount.
  always_comb begin
    eff_amt = amt_ext;
    if (mode_t'(in_mode) != MODE_ROL && amt_ext > CNT_W'(WIDTH)) begin
      eff_amt = CNT_W'(WIDTH);
    end
  end

  always_comb begin
    step_dat = work;
    case (mode)
      MODE_LSL: step_dat = {work[WIDTH-2:0], 1'b0};
      MODE_LSR: step_dat = {1'b0, work[WIDTH-1:1]};
      MODE_ASR: step_dat = {work[WIDTH-1], work[WIDTH-1:1]};
      MODE_ROL: step_dat = {work[WIDTH-2:0], work[WIDTH-1]};
      default:  step_dat = work;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    work_nxt  = work;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          work_nxt  = in_data;
          mode_nxt  = mode_t'(in_mode);
          cnt_nxt   = eff_amt;
          state_nxt = (eff_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_nxt = step_dat;
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode  <= MODE_LSL;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mode  <= mode_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;

endmodule
